// File: rtl/pipe_stage_skid_reg.sv
// Elastic PC/instruction pipeline register with a one-entry skid buffer.
// Start gate with programmable delay, NOP on flush, saturating stall/flush counters.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   startProcess             start gate, sampled only while idle
//   inValid/inReady          upstream handshake (inReady is a flop)
//   pcIn, instructionIn      upstream payload
//   flush                    branch-taken flush, honoured only while running
//   outValid/outReady        downstream handshake (outValid is a flop)
//   pcOut, instructionOut    payload to the next stage
//   stallCount, flushCount   saturating event counters
module pipe_stage_skid_reg #(
    parameter int              PC_W        = 32,
    parameter int              INSTR_W     = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
    parameter int              START_DELAY = 2,
    parameter int              CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startProcess,
    input  logic               inValid,
    output logic               inReady,
    input  logic [PC_W-1:0]    pcIn,
    input  logic [INSTR_W-1:0] instructionIn,
    input  logic               flush,
    output logic               outValid,
    input  logic               outReady,
    output logic [PC_W-1:0]    pcOut,
    output logic [INSTR_W-1:0] instructionOut,
    output logic [CNT_W-1:0]   stallCount,
    output logic [CNT_W-1:0]   flushCount
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    localparam int DW = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
    localparam logic [DW-1:0]    DLY_END = DW'(START_DELAY);
    localparam logic [DW-1:0]    DLY_ONE = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t               state_q, state_d;
    logic [DW-1:0]        dly_q, dly_d;
    logic                 out_valid_q, out_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic [PC_W-1:0]      pc_out_q, pc_out_d;
    logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic accept;
    logic drain;

    // inReady is only ever high in RUN, so accept needs no state term.
    assign accept = inValid && in_ready_q;
    assign drain  = !out_valid_q || outReady;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        pc_out_d     = pc_out_q;
        instr_out_d  = instr_out_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Warm-up pass-through so the next stage sees live data.
                pc_out_d    = pcIn;
                instr_out_d = instructionIn;
                if (startProcess) begin
                    if (START_DELAY == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT;
                        dly_d   = DLY_ONE;
                    end
                end
            end
            ST_WAIT: begin
                pc_out_d    = pcIn;
                instr_out_d = instructionIn;
                if (dly_q == DLY_END) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q + DLY_ONE;
                end
            end
            ST_RUN: begin
                if (out_valid_q && !outReady && stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
                if (flush) begin
                    // Kills both held beats and any beat accepted this cycle.
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_out_d     = '0;
                    instr_out_d  = NOP_INSTR;
                    if (flush_cnt_q != CNT_MAX) begin
                        flush_cnt_d = flush_cnt_q + CNT_ONE;
                    end
                end else if (drain && skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    pc_out_d     = skid_pc_q;
                    instr_out_d  = skid_instr_q;
                end else if (drain) begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        pc_out_d    = pcIn;
                        instr_out_d = instructionIn;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = pcIn;
                    skid_instr_d = instructionIn;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready: looks at the next skid state, not at outReady.
        in_ready_d = (state_d == ST_RUN) && !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dly_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            pc_out_q     <= '0;
            instr_out_q  <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign inReady        = in_ready_q;
    assign outValid       = out_valid_q;
    assign pcOut          = pc_out_q;
    assign instructionOut = instr_out_q;
    assign stallCount     = stall_cnt_q;
    assign flushCount     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: queue-based reference model plus directed
// and random stimulus; a second instance covers CNT_W=2, START_DELAY=0.
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int DLY = 2;
    localparam int MAXC = 65535;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] pc_out, instr_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        b_rst = 1'b1;
    logic        b_start = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_out_ready = 1'b0;
    logic        b_flush = 1'b0;
    logic [31:0] b_pc_in = '0;
    logic [31:0] b_instr_in = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_pc_out, b_instr_out;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    pipe_stage_skid_reg dut (
        .clk(clk), .rst(rst), .startProcess(start),
        .inValid(in_valid), .inReady(in_ready),
        .pcIn(pc_in), .instructionIn(instr_in),
        .flush(flush), .outValid(out_valid), .outReady(out_ready),
        .pcOut(pc_out), .instructionOut(instr_out),
        .stallCount(stall_cnt), .flushCount(flush_cnt)
    );

    pipe_stage_skid_reg #(.CNT_W(2), .START_DELAY(0)) dut2 (
        .clk(clk), .rst(b_rst), .startProcess(b_start),
        .inValid(b_in_valid), .inReady(b_in_ready),
        .pcIn(b_pc_in), .instructionIn(b_instr_in),
        .flush(b_flush), .outValid(b_out_valid), .outReady(b_out_ready),
        .pcOut(b_pc_out), .instructionOut(b_instr_out),
        .stallCount(b_stall_cnt), .flushCount(b_flush_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting, 2 running; the stage is a
    // two-deep FIFO whose head is the visible output.
    int          m_phase = 0;
    int          m_wcnt = 0;
    int          m_stall = 0;
    int          m_flush = 0;
    beat_t       m_q[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_ins = NOP;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0;
            m_wcnt = 0;
            m_stall = 0;
            m_flush = 0;
            m_q.delete();
            m_pc = '0;
            m_ins = NOP;
        end else if (m_phase != 2) begin
            m_pc = pc_in;
            m_ins = instr_in;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = (DLY == 0) ? 2 : 1;
                    m_wcnt = 1;
                end
            end else if (m_wcnt == DLY) begin
                m_phase = 2;
            end else begin
                m_wcnt++;
            end
        end else begin
            if (m_q.size() > 0 && !out_ready && m_stall < MAXC) m_stall++;
            if (flush) begin
                m_q.delete();
                m_pc = '0;
                m_ins = NOP;
                if (m_flush < MAXC) m_flush++;
            end else begin
                automatic bit can_push = (m_q.size() < 2);
                if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
                if (in_valid && can_push) m_q.push_back('{pc_in, instr_in});
                if (m_q.size() > 0) begin
                    m_pc = m_q[0].pc;
                    m_ins = m_q[0].ins;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("outValid", out_valid, (m_phase == 2 && m_q.size() > 0));
        chk("inReady", in_ready, (m_phase == 2 && m_q.size() < 2));
        chk("pcOut", pc_out, m_pc);
        chk("instructionOut", instr_out, m_ins);
        chk("stallCount", stall_cnt, m_stall);
        chk("flushCount", flush_cnt, m_flush);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic v, input logic [31:0] pc);
        in_valid = v;
        pc_in = pc;
        instr_in = pc ^ 32'hA5A5_0000;
    endtask

    initial begin
        // T1: reset, start gate, delay of 2
        tick();
        chk("t1_rst_instr", instr_out, NOP);
        chk("t1_rst_pc", pc_out, 32'h0);
        chk("t1_rst_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_wait_ready", in_ready, 0);
        chk("t1_wait_valid", out_valid, 0);
        tick();
        chk("t1_wait2_ready", in_ready, 0);
        tick();
        chk("t1_run_ready", in_ready, 1);

        // T2: unstalled stream, one cycle latency
        out_ready = 1'b1;
        beat(1, 32'h100);
        tick();
        chk("t2_pc0", pc_out, 32'h100);
        chk("t2_v0", out_valid, 1);
        beat(1, 32'h104);
        tick();
        chk("t2_pc1", pc_out, 32'h104);
        beat(1, 32'h108);
        tick();
        chk("t2_pc2", pc_out, 32'h108);
        beat(0, 32'h0);
        tick();
        chk("t2_drained", out_valid, 0);
        chk("t2_stall", stall_cnt, 0);

        // T3: stall fills the skid
        out_ready = 1'b0;
        beat(1, 32'h200);
        tick();
        beat(1, 32'h204);
        tick();
        beat(0, 32'h0);
        chk("t3_skid_ready", in_ready, 0);
        tick();
        tick();
        chk("t3_stall3", stall_cnt, 3);
        chk("t3_hold_pc", pc_out, 32'h200);
        out_ready = 1'b1;
        tick();
        chk("t3_pc_skid", pc_out, 32'h204);
        chk("t3_ready_back", in_ready, 1);
        tick();
        chk("t3_empty", out_valid, 0);

        // T4: flush with full skid and an incoming beat
        out_ready = 1'b0;
        beat(1, 32'h300);
        tick();
        beat(1, 32'h304);
        tick();
        beat(1, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        beat(0, 32'h0);
        chk("t4_valid", out_valid, 0);
        chk("t4_pc", pc_out, 32'h0);
        chk("t4_nop", instr_out, NOP);
        chk("t4_ready", in_ready, 1);
        chk("t4_fcnt", flush_cnt, 1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t4_no_ghost", out_valid, 0);

        // T5: async reset in the middle of a stall
        out_ready = 1'b0;
        beat(1, 32'h400);
        tick();
        beat(1, 32'h404);
        tick();
        beat(0, 32'h0);
        rst = 1'b1;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 0);
        chk("t5_stall", stall_cnt, 0);
        chk("t5_flush", flush_cnt, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_idle", in_ready, 0);

        // Random traffic with occasional reset and start pulses
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            pc_in = $urandom;
            instr_in = $urandom;
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;

        // T6: narrow counters, zero start delay
        tick();
        b_rst = 1'b0;
        tick();
        chk("t6_idle", b_in_ready, 0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("t6_run", b_in_ready, 1);
        chk("t6_valid", b_out_valid, 0);
        b_flush = 1'b1;
        tick();
        tick();
        chk("t6_f2", b_flush_cnt, 2);
        tick();
        tick();
        tick();
        b_flush = 1'b0;
        chk("t6_fsat", b_flush_cnt, 3);
        chk("t6_fnop", b_instr_out, NOP);
        b_in_valid = 1'b1;
        b_pc_in = 32'h500;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_ssat", b_stall_cnt, 3);
        chk("t6_hold", b_pc_out, 32'h500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
